// File: rtl/piece_scheduler_if.sv
// Game-logic side of the piece scheduler.
// The head piece is handed over with a valid/ready handshake, and the
// second FIFO entry is published as a preview.
//
//   out_valid  : head piece available (FIFO non-empty)
//   out_ready  : game logic takes the head piece this cycle
//   out_piece  : head piece ID 0..6, 0 when empty
//   next_valid : a second entry exists
//   next_piece : second entry, 0 when next_valid = 0
//
// The scheduler uses the master modport and the game logic uses the slave modport.
interface piece_scheduler_if;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_piece;
    logic       next_valid;
    logic [2:0] next_piece;

    modport master (
        output out_valid,
        output out_piece,
        output next_valid,
        output next_piece,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_piece,
        input  next_valid,
        input  next_piece,
        output out_ready
    );
endinterface

// File: rtl/piece_scheduler.sv
// 7-bag tetromino scheduler.
// Each cycle it takes a candidate piece from the free-running LFSR and
// rejection-samples it against the current bag. It buffers accepted pieces
// in a lookahead shift-register FIFO and serves them to game logic.
// Every aligned group of 7 issued pieces is a permutation of 0..6.
//
// Parameters
//   DEPTH     : lookahead FIFO entries (2..8)
//   MAX_TRIES : consecutive rejections before the deterministic fallback (1..15)
//
// Ports
//   clk      : system clock, rising edge
//   reset    : asynchronous active-high reset, clears all state
//   rnd      : LFSR output; only rnd[2:0] forms the candidate
//   flush    : one-cycle new-game pulse; empties the FIFO and the bag
//   bus      : handshake/preview interface towards game logic (master)
//   bag_mask : bit i set = piece i already drawn from the current bag
module piece_scheduler #(
    parameter int DEPTH     = 4,
    parameter int MAX_TRIES = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [14:0]              rnd,
    input  logic                     flush,
    piece_scheduler_if.master        bus,
    output logic [6:0]               bag_mask
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [2:0] fifo      [DEPTH];
    logic [2:0] fifo_next [DEPTH];
    logic [3:0] count;
    logic [3:0] tries;
    logic [6:0] mask;

    // ------------------------------------------------------------------
    // Draw decision
    // ------------------------------------------------------------------
    logic [2:0] cand;
    logic       reject;
    logic       forced;
    logic       draw;
    logic       accept;
    logic       pop;
    logic [2:0] piece;
    logic [6:0] mask_set;
    logic [3:0] wr_idx;

    // The upper LFSR bits are deliberately ignored.
    logic unused_rnd_bits;
    assign unused_rnd_bits = ^rnd[14:3];

    // Returns the lowest-index piece not yet drawn from the bag.
    // The bag never holds all seven pieces because it is refilled on the
    // seventh accept, so at least one bit is always clear.
    function automatic logic [2:0] first_clear(input logic [6:0] m);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 6; i >= 0; i--) begin
            if (!m[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    always_comb begin
        cand   = rnd[2:0];
        // Candidate 7 is not a piece. Guard it before indexing the mask.
        reject = (cand == 3'd7) ? 1'b1 : mask[cand];
        forced = reject && (tries == 4'(MAX_TRIES - 1));
        draw   = (count < 4'(DEPTH)) && !flush;
        accept = draw && (!reject || forced);
        pop    = bus.out_valid && bus.out_ready && !flush;
        piece  = reject ? first_clear(mask) : cand;
        mask_set = mask | (7'd1 << piece);
        // When the FIFO pops in the same cycle, the tail slot moves down by one.
        wr_idx = pop ? (count - 4'd1) : count;
    end

    // ------------------------------------------------------------------
    // FIFO next-state: shift toward the head on pop, write the tail on accept
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            fifo_next[i] = fifo[i];
        end
        if (pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                fifo_next[i] = fifo[i + 1];
            end
        end
        if (accept) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (4'(i) == wr_idx) fifo_next[i] = piece;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= 4'd0;
            tries <= 4'd0;
            mask  <= 7'd0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo[i] <= 3'd0;
            end
        end else if (flush) begin
            // A new game discards everything that is buffered, including a same-cycle pop.
            count <= 4'd0;
            tries <= 4'd0;
            mask  <= 7'd0;
        end else begin
            if (draw) begin
                tries <= accept ? 4'd0 : (tries + 4'd1);
            end
            if (accept) begin
                // Completing the bag starts a fresh one immediately.
                mask <= (mask_set == 7'h7F) ? 7'h00 : mask_set;
            end
            for (int i = 0; i < DEPTH; i++) begin
                fifo[i] <= fifo_next[i];
            end
            count <= count + {3'd0, accept} - {3'd0, pop};
        end
    end

    // ------------------------------------------------------------------
    // Outputs, decoded purely from registered state
    // ------------------------------------------------------------------
    always_comb begin
        bus.out_valid  = (count != 4'd0);
        bus.out_piece  = bus.out_valid ? fifo[0] : 3'd0;
        bus.next_valid = (count >= 4'd2);
        bus.next_piece = bus.next_valid ? fifo[1] : 3'd0;
        bag_mask       = mask;
    end

endmodule

// File: tb/tb_piece_scheduler.sv
// Directed bench for piece_scheduler (DEPTH=4, MAX_TRIES=8).
// The stimulus pushes expected pieces into a queue. A negedge monitor pops
// and compares them on each handshake. In the LFSR phase it checks instead
// that each group of seven issued pieces is a permutation and that the bag
// mask evolves correctly.
module tb_piece_scheduler;
    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic [14:0] rnd;
    logic [6:0]  bag_mask;
    logic [14:0] lfsr;

    piece_scheduler_if bus ();

    piece_scheduler #(
        .DEPTH     (4),
        .MAX_TRIES (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rnd      (rnd),
        .flush    (flush),
        .bus      (bus),
        .bag_mask (bag_mask)
    );

    always #5 clk = ~clk;

    int         n_cmp  = 0;
    int         n_fail = 0;
    int         exp_q[$];
    int         mode   = 0;      // 0: scoreboard queue, 1: bag-property checks
    int         grp_cnt = 0;
    int         groups  = 0;
    logic [6:0] grp_seen = 7'd0;
    logic [6:0] prev_mask = 7'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Handshake monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (!reset && !flush && bus.out_valid && bus.out_ready) begin
            if (mode == 0) begin
                if (exp_q.size() == 0) check("pop_unexpected", 32'(exp_q.size()), 32'd1);
                else check("pop", 32'(bus.out_piece), 32'(exp_q.pop_front()));
            end else begin
                grp_seen = grp_seen | 7'(8'd1 << bus.out_piece);
                grp_cnt++;
                if (grp_cnt == 7) begin
                    check("bag_perm", 32'(grp_seen), 32'h7F);
                    grp_seen = 7'd0;
                    grp_cnt  = 0;
                    groups++;
                end
            end
        end
        if (mode == 1) begin
            if (bag_mask !== prev_mask) begin
                if ($countones(prev_mask) == 6)
                    check("bag_refill", 32'(bag_mask), 32'h0);
                else
                    check("bag_grow",
                          32'(($countones(bag_mask) == $countones(prev_mask) + 1) &&
                              ((bag_mask & prev_mask) == prev_mask)), 32'd1);
            end
            prev_mask = bag_mask;
        end
    end

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        rnd   = 15'd0;
        bus.out_ready = 1'b0;
        lfsr  = 15'h0001;
        repeat (2) tick();
        check("rst_out_valid",  32'(bus.out_valid),  32'd0);
        check("rst_out_piece",  32'(bus.out_piece),  32'd0);
        check("rst_next_valid", 32'(bus.next_valid), 32'd0);
        check("rst_next_piece", 32'(bus.next_piece), 32'd0);
        check("rst_bag_mask",   32'(bag_mask),       32'd0);

        // Test 1: first draws 3,3,7,0,5
        reset = 1'b0;
        rnd = 15'd3; tick();
        check("t1_first_valid", 32'(bus.out_valid), 32'd1);
        check("t1_first_piece", 32'(bus.out_piece), 32'd3);
        check("t1_first_mask",  32'(bag_mask),      32'h08);
        rnd = 15'd3; tick();
        rnd = 15'd7; tick();
        check("t1_rejects_next_valid", 32'(bus.next_valid), 32'd0);
        rnd = 15'd0; tick();
        rnd = 15'd5; tick();
        exp_q.push_back(3); exp_q.push_back(0); exp_q.push_back(5);
        check("t1_out_piece",  32'(bus.out_piece),  32'd3);
        check("t1_next_valid", 32'(bus.next_valid), 32'd1);
        check("t1_next_piece", 32'(bus.next_piece), 32'd0);
        check("t1_bag_mask",   32'(bag_mask),       32'b0101001);
        bus.out_ready = 1'b1;
        rnd = 15'd7;
        repeat (3) tick();
        check("t1_drained_valid", 32'(bus.out_valid), 32'd0);
        check("t1_queue_empty",   32'(exp_q.size()),  32'd0);
        bus.out_ready = 1'b0;

        // Test 2: full FIFO
        flush = 1'b1; tick(); flush = 1'b0;
        check("flush_valid", 32'(bus.out_valid), 32'd0);
        check("flush_mask",  32'(bag_mask),      32'd0);
        for (int i = 0; i < 4; i++) begin
            rnd = 15'(i); tick();
            exp_q.push_back(i);
        end
        rnd = 15'd4; tick();
        check("t2_full_mask",  32'(bag_mask),       32'h0F);
        check("t2_full_head",  32'(bus.out_piece),  32'd0);
        check("t2_full_next",  32'(bus.next_piece), 32'd1);
        bus.out_ready = 1'b1; tick(); bus.out_ready = 1'b0;
        check("t2_pop_head",   32'(bus.out_piece),  32'd1);
        check("t2_pop_next",   32'(bus.next_piece), 32'd2);
        check("t2_pop_nodraw", 32'(bag_mask),       32'h0F);
        tick();
        exp_q.push_back(4);
        check("t2_late_draw",  32'(bag_mask),       32'h1F);

        // Test 5: flush against a same-cycle pop
        rnd = 15'd7; bus.out_ready = 1'b1; tick();       // pops 1, leaves 3 entries
        flush = 1'b1; tick();
        flush = 1'b0; bus.out_ready = 1'b0;
        exp_q.delete();
        check("t5_out_valid",  32'(bus.out_valid),  32'd0);
        check("t5_next_valid", 32'(bus.next_valid), 32'd0);
        check("t5_bag_mask",   32'(bag_mask),       32'd0);
        rnd = 15'd6; tick();
        check("t5_draw_head",  32'(bus.out_piece),  32'd6);
        check("t5_draw_one",   32'(bus.next_valid), 32'd0);
        rnd = 15'd6; tick();
        check("t5_dup_reject", 32'(bus.next_valid), 32'd0);
        rnd = 15'd2; tick();
        check("t5_draw_next",  32'(bus.next_piece), 32'd2);
        check("t5_mask",       32'(bag_mask),       32'b1000100);

        // Test 6: asynchronous reset between edges
        rnd = 15'd7; tick();                              // try counter now 1
        #2 reset = 1'b1;
        #1;
        check("t6_async_valid", 32'(bus.out_valid),  32'd0);
        check("t6_async_piece", 32'(bus.out_piece),  32'd0);
        check("t6_async_next",  32'(bus.next_valid), 32'd0);
        check("t6_async_npc",   32'(bus.next_piece), 32'd0);
        check("t6_async_mask",  32'(bag_mask),       32'd0);
        exp_q.delete();
        tick();
        reset = 1'b0;
        rnd = 15'd3; tick();
        exp_q.push_back(3);
        check("t6_redraw_piece", 32'(bus.out_piece), 32'd3);
        check("t6_redraw_mask",  32'(bag_mask),      32'h08);

        // Test 4: fallback after MAX_TRIES rejections
        bus.out_ready = 1'b1;
        rnd = 15'd1; tick(); exp_q.push_back(1);
        rnd = 15'd4; tick(); exp_q.push_back(4);
        rnd = 15'd5; tick(); exp_q.push_back(5);
        rnd = 15'd6; tick(); exp_q.push_back(6);
        bus.out_ready = 1'b0;
        check("t4_setup_mask", 32'(bag_mask), 32'b1111010);
        rnd = 15'd7;
        repeat (7) tick();
        check("t4_no_early_fallback", 32'(bus.next_valid), 32'd0);
        check("t4_mask_hold",         32'(bag_mask),       32'b1111010);
        tick();
        exp_q.push_back(0);
        check("t4_forced0_valid", 32'(bus.next_valid), 32'd1);
        check("t4_forced0_piece", 32'(bus.next_piece), 32'd0);
        check("t4_forced0_mask",  32'(bag_mask),       32'b1111011);
        repeat (7) tick();
        check("t4_second_hold",   32'(bag_mask),       32'b1111011);
        tick();
        exp_q.push_back(2);
        check("t4_forced2_refill", 32'(bag_mask), 32'd0);
        bus.out_ready = 1'b1;
        repeat (3) tick();
        bus.out_ready = 1'b0;
        check("t4_queue_empty", 32'(exp_q.size()), 32'd0);

        // Test 3: bag property over an LFSR sequence
        flush = 1'b1; tick(); flush = 1'b0;
        exp_q.delete();
        prev_mask = 7'd0;
        grp_seen  = 7'd0;
        grp_cnt   = 0;
        groups    = 0;
        mode      = 1;
        bus.out_ready = 1'b1;
        for (int cyc = 0; cyc < 3000 && groups < 10; cyc++) begin
            rnd = lfsr;
            tick();
            lfsr = {lfsr[13:0], lfsr[14] ^ lfsr[13]};
        end
        bus.out_ready = 1'b0;
        mode = 0;
        check("t3_groups", 32'(groups), 32'd10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/piece_scheduler.md
# piece_scheduler

7-bag tetromino scheduler between the free-running 15-bit LFSR and the game-logic core. Each cycle it samples the LFSR output and uses rejection sampling against a 7-bit bag mask to draw piece IDs 0..6. Every aligned group of 7 consecutive issued pieces is a permutation of 0..6. Drawn pieces are buffered in a small lookahead FIFO. The head is handed to game logic over a valid/ready handshake, and the second entry is exposed as the "next piece" preview.

## Interface
- DEPTH, 4: lookahead FIFO entries (2..8)
- MAX_TRIES, 8: consecutive rejected draws before deterministic fallback (1..15)
- clk  input  1  system clock; all state changes on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- rnd  input  15  LFSR output; sampled every cycle; only rnd[2:0] used as candidate
- flush  input  1  synchronous one-cycle pulse: new game; empties FIFO and bag
- out_ready  input  1  game logic accepts head piece this cycle
- out_valid  output  1  FIFO non-empty
- out_piece  output  3  head piece ID (0..6); 0 when empty
- next_valid  output  1  FIFO holds ≥2 entries
- next_piece  output  3  second FIFO entry; 0 when next_valid=0
- bag_mask  output  7  bit i set = piece i already drawn from current bag

## Operation
- **Reset values:** all outputs 0, FIFO count 0, bag_mask 0, try counter 0.
- **Draw condition:** a draw is attempted in every cycle where registered count < DEPTH and flush=0.
- **Candidate:** c = rnd[2:0]. The candidate is rejected if c==7 or bag_mask[c]==1.
- **Accept:**
  - c is pushed to the FIFO tail.
  - bag_mask[c] is set.
  - The try counter is cleared.
- **Reject:** the try counter increments.
  - If the counter was already MAX_TRIES-1, the draw is instead forced-accepted with the lowest-index clear bit of bag_mask, and the counter is cleared.
  - The fallback therefore fires on the MAX_TRIES-th consecutive rejection.
- **Bag refill:** if an accept (normal or forced) would make bag_mask 7'h7F, bag_mask becomes 7'h00 next cycle instead. The next draw starts a fresh bag.
- **Pop:** occurs when out_valid && out_ready. The head is removed and entries shift toward the head.
- **Simultaneous push and pop:**
  - Allowed when count < DEPTH; count is unchanged.
  - When count == DEPTH, no push that cycle. The draw resumes next cycle.
- **Flush:**
  - Next cycle: count=0, bag_mask=0, try counter=0.
  - Overrides any push or pop in the same cycle.
  - No draw in the flush cycle.
- **Reset mid-operation:** reset asserted at any point clears everything asynchronously. Drawing resumes on the first rising edge after reset deasserts.
- **FIFO:** implemented as a shift register or circular buffer with a registered count 0..DEPTH. All outputs are decoded from registers; no combinational path from rnd or out_ready to outputs.

## Timing
- **Draw latency:** a candidate accepted at edge N is visible in FIFO state after edge N. If the FIFO was empty, out_valid=1 and out_piece=c in cycle N+1.
- **Throughput:** at most one push per cycle and one pop per cycle.
- **Startup from reset:** with all-valid candidates, the FIFO reaches DEPTH entries after DEPTH cycles.
- **Worst-case draw latency:** a single draw completes in at most MAX_TRIES cycles.
- **Pop visibility:** out_piece/next_piece update on the edge after a pop. A newly exposed head is valid the same cycle count reflects it.
- **Flush latency:** flush at edge N gives out_valid=0 and bag_mask=0 after edge N. The first draw of the new game is attempted in cycle N+1.

## Test plan
1. **Reset and first draws:** hold out_ready=0; drive rnd[2:0] = 3,3,7,0,5 on consecutive cycles from the first edge after reset.
   - Candidates 3, 0, 5 accepted; the second 3 and the 7 rejected.
   - out_piece=3 and next_piece=0; bag_mask=7'b0101001 after five edges.
2. **Full FIFO:** DEPTH=4, out_ready=0, rnd[2:0] = 0,1,2,3,4.
   - FIFO holds 0,1,2,3; candidate 4 is not drawn; bag_mask=7'h0F.
   - Assert out_ready for one cycle: head becomes 1, next_piece=2. Piece 4 is pushed on the following edge.
3. **Bag property:** rnd = a reference LFSR sequence, out_ready=1 continuously, 70 pops.
   - Each of the 10 aligned groups of 7 pops is a permutation of 0..6.
   - bag_mask returns to 0 after every 7th accept.
4. **Fallback:** MAX_TRIES=8, bag_mask=7'b1111010 (pieces 0 and 2 outstanding), hold rnd[2:0]=7.
   - Piece 0 is force-accepted on the 8th rejection.
   - Next, after 8 more cycles at 7, piece 2 is force-accepted and bag_mask clears to 0.
5. **Flush vs pop:** FIFO holds 3 entries; assert flush and out_ready in the same cycle.
   - Next cycle: out_valid=0, next_valid=0, bag_mask=0.
   - One piece is then drawn per accepted candidate.
6. **Asynchronous reset mid-operation:** assert reset between clock edges while the FIFO holds 2 entries and the try counter is non-zero.
   - All outputs go to 0 immediately.
   - After deassert, the first draw matches the reset-state behaviour of test 1.
